// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: a held lock restricts the choice to its owner,
// otherwise the round-robin pointer decides between competing requests.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       lock_active,
  input  logic       owner,
  output logic       grant_valid,
  output logic       grant_id
);

  // Pick the lock owner, else the requester at rr_ptr, else the other one
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_CPU;
    if (lock_active) begin
      grant_valid = req[owner];
      grant_id    = owner;
    end else if (req[rr_ptr]) begin
      grant_valid = 1'b1;
      grant_id    = rr_ptr;
    end else if (req[~rr_ptr]) begin
      grant_valid = 1'b1;
      grant_id    = ~rr_ptr;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between a processor and an auxiliary requester
// with req/ack handshakes, round-robin fairness, optional locking for
// read-modify-write sequences and a watchdog on long-held locks.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int LAT      = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy,
  output logic          lock_err
);

  localparam int              CW         = $clog2(LOCK_MAX + 1);
  localparam logic [1:0]      WAIT_INIT  = 2'(LAT - 1);
  localparam logic [CW-1:0]   LOCK_LIMIT = CW'(LOCK_MAX);

  arb_state_t    state;
  arb_state_t    state_next;
  logic          rr_ptr;
  logic          lock_active;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] lock_cnt_inc;
  logic [1:0]    wait_cnt;
  logic          we_q;
  logic          grant_valid;
  logic          grant_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          owner_req;
  logic          owner_lock;

  mem_arb_pick u_pick (
    .req         ({m1_req, m0_req}),
    .rr_ptr      (rr_ptr),
    .lock_active (lock_active),
    .owner       (owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we       = (grant_id == REQ_AUX) ? m1_we    : m0_we;
  assign sel_addr     = (grant_id == REQ_AUX) ? m1_addr  : m0_addr;
  assign sel_wdata    = (grant_id == REQ_AUX) ? m1_wdata : m0_wdata;
  assign owner_req    = (owner == REQ_AUX) ? m1_req  : m0_req;
  assign owner_lock   = (owner == REQ_AUX) ? m1_lock : m0_lock;
  assign lock_cnt_inc = lock_cnt + CW'(1);

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the state-decoded busy flag and ack pulses
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (we_q || (wait_cnt == 2'd0)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        busy       = 1'b1;
        m0_ack     = (owner == REQ_CPU);
        m1_ack     = (owner == REQ_AUX);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant latching, memory port drive, read capture, fairness and lock bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= REQ_CPU;
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      lock_err    <= 1'b0;
      wait_cnt    <= 2'd0;
      we_q        <= 1'b0;
      owner       <= REQ_CPU;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_write   <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            we_q      <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_write <= sel_we;
            owner     <= grant_id;
            wait_cnt  <= WAIT_INIT;
            if (!lock_active) begin
              rr_ptr <= ~grant_id;
            end
          end else if (lock_active && !owner_req && !owner_lock) begin
            lock_active <= 1'b0;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (wait_cnt == 2'd0) begin
              if (owner == REQ_AUX) begin
                m1_rdata <= mem_rdata;
              end else begin
                m0_rdata <= mem_rdata;
              end
            end else begin
              wait_cnt <= wait_cnt - 2'd1;
            end
          end
        end
        RESP: begin
          if (owner_lock) begin
            if (lock_cnt_inc == LOCK_LIMIT) begin
              lock_active <= 1'b0;
              lock_cnt    <= '0;
              lock_err    <= 1'b1;
              rr_ptr      <= ~owner;
            end else begin
              lock_active <= 1'b1;
              lock_cnt    <= lock_cnt_inc;
            end
          end else begin
            lock_active <= 1'b0;
            lock_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: three instances with different
// latency / watchdog settings share the requester inputs, one is selected
// at a time and compared cycle by cycle against a transaction-timeline model.
module tb_mem_arbiter;

  typedef struct packed {
    logic       we;
    logic       lock;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [7:0] mem_arr [256];

  logic [2:0]  ack0_v, ack1_v, mw_v, own_v, busy_v, lerr_v;
  logic [23:0] r0_v, r1_v, ma_v, mwd_v;

  // Instance 0: LAT=1, instance 1: LAT=3 with LOCK_MAX=2, instance 2: LAT=4
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GLAT  = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int GLMAX = (g == 1) ? 2 : 8;
    logic       a0, a1, mw, ow, bz, le;
    logic [7:0] r0, r1, ma, mwd, mrd, d1, d2, d3;

    mem_arbiter #(.AW(8), .DW(8), .LAT(GLAT), .LOCK_MAX(GLMAX)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_lock(m0_lock), .m0_ack(a0), .m0_rdata(r0),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock), .m1_ack(a1), .m1_rdata(r1),
      .mem_addr(ma), .mem_wdata(mwd), .mem_write(mw), .mem_rdata(mrd),
      .owner(ow), .busy(bz), .lock_err(le)
    );

    // Memory model: data for an address appears LAT-1 edges after it
    always @(posedge clk) begin
      d1 <= mem_arr[ma];
      d2 <= d1;
      d3 <= d2;
    end
    assign mrd = (GLAT == 1) ? mem_arr[ma] : (GLAT == 2) ? d1 : (GLAT == 3) ? d2 : d3;

    assign ack0_v[g] = a0;
    assign ack1_v[g] = a1;
    assign mw_v[g]   = mw;
    assign own_v[g]  = ow;
    assign busy_v[g] = bz;
    assign lerr_v[g] = le;
    assign r0_v[g*8 +: 8]  = r0;
    assign r1_v[g*8 +: 8]  = r1;
    assign ma_v[g*8 +: 8]  = ma;
    assign mwd_v[g*8 +: 8] = mwd;
  end

  int errors = 0;
  int checks = 0;
  int cur, lat, lmax, cyc;
  bit rand_mode;

  // Reference model: one transaction timeline plus fairness/lock bookkeeping
  bit         tx_on, tx_who, tx_we;
  int         tx_age, tx_len;
  logic [7:0] tx_addr;
  bit         rr_m, lk_on, own_m, lerr_m;
  int         lk_cnt;
  logic [7:0] rd_m [2];
  logic [7:0] maddr_m, mwd_m;
  bit         ack_e [2];

  txn_t q0[$];
  txn_t q1[$];

  int         ack_cnt [2];
  int         first_ack [2];
  int         mw_cnt, held_cnt;
  int         ack_order[$];
  logic [7:0] mw_addr_seen, mw_data_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d, dut %0d)", tag, obs, exp, cyc, cur);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic lock, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.lock  = ($urandom_range(0, 2) == 0);
    t.addr  = 8'($urandom);
    t.wdata = 8'($urandom);
    return t;
  endfunction

  task automatic model_reset();
    tx_on = 0; tx_who = 0; tx_we = 0; tx_age = 0; tx_len = 0; tx_addr = 8'h00;
    rr_m = 0; lk_on = 0; lk_cnt = 0; own_m = 0; lerr_m = 0;
    rd_m[0] = 8'h00; rd_m[1] = 8'h00; maddr_m = 8'h00; mwd_m = 8'h00;
    ack_e[0] = 0; ack_e[1] = 0;
    q0.delete(); q1.delete(); ack_order.delete();
    ack_cnt[0] = 0; ack_cnt[1] = 0; first_ack[0] = -1; first_ack[1] = -1;
    mw_cnt = 0; held_cnt = 0; mw_addr_seen = 8'h00; mw_data_seen = 8'h00; cyc = 0;
    m0_req = 0; m0_we = 0; m0_addr = 8'h00; m0_wdata = 8'h00; m0_lock = 0;
    m1_req = 0; m1_we = 0; m1_addr = 8'h00; m1_wdata = 8'h00; m1_lock = 0;
  endtask

  // Compare every DUT output of the selected instance with the model
  task automatic checkOutput();
    ack_e[0] = tx_on && (tx_age == tx_len) && (tx_who == 1'b0);
    ack_e[1] = tx_on && (tx_age == tx_len) && (tx_who == 1'b1);
    if (tx_on && (tx_age == tx_len) && !tx_we) rd_m[tx_who] = mem_arr[tx_addr];
    chk("busy",      busy_v[cur], tx_on);
    chk("mem_write", mw_v[cur], tx_on && tx_we && (tx_age == 1));
    chk("m0_ack",    ack0_v[cur], ack_e[0]);
    chk("m1_ack",    ack1_v[cur], ack_e[1]);
    chk("owner",     own_v[cur], own_m);
    chk("lock_err",  lerr_v[cur], lerr_m);
    chk("m0_rdata",  r0_v[cur*8 +: 8], rd_m[0]);
    chk("m1_rdata",  r1_v[cur*8 +: 8], rd_m[1]);
    chk("mem_addr",  ma_v[cur*8 +: 8], maddr_m);
    chk("mem_wdata", mwd_v[cur*8 +: 8], mwd_m);
    if (ack0_v[cur] === 1'b1) begin
      ack_order.push_back(0); ack_cnt[0]++;
      if (first_ack[0] < 0) first_ack[0] = cyc;
    end
    if (ack1_v[cur] === 1'b1) begin
      ack_order.push_back(1); ack_cnt[1]++;
      if (first_ack[1] < 0) first_ack[1] = cyc;
    end
    if (mw_v[cur] === 1'b1) begin
      mw_cnt++; mw_addr_seen = ma_v[cur*8 +: 8]; mw_data_seen = mwd_v[cur*8 +: 8];
    end
    if (busy_v[cur] === 1'b1 && ack0_v[cur] !== 1'b1 && ack1_v[cur] !== 1'b1) held_cnt++;
  endtask

  // Advance the model across one rising edge using the inputs seen at that edge
  task automatic model_advance();
    logic [1:0] req_m;
    logic [1:0] lock_m;
    bit found, w;
    req_m  = {m1_req, m0_req};
    lock_m = {m1_lock, m0_lock};
    found  = 0;
    w      = 0;
    if (tx_on) begin
      if (tx_age == tx_len) begin
        tx_on = 0;
        if (lock_m[tx_who]) begin
          if (lk_cnt + 1 == lmax) begin
            lk_on = 0; lk_cnt = 0; lerr_m = 1; rr_m = !tx_who;
          end else begin
            lk_on = 1; lk_cnt++;
          end
        end else begin
          lk_on = 0; lk_cnt = 0;
        end
      end else begin
        tx_age++;
      end
    end else begin
      if (lk_on) begin
        if (req_m[own_m]) begin found = 1; w = own_m; end
        else if (!lock_m[own_m]) lk_on = 0;
      end else if (req_m[rr_m]) begin
        found = 1; w = rr_m;
      end else if (req_m[!rr_m]) begin
        found = 1; w = !rr_m;
      end
      if (found) begin
        tx_on   = 1; tx_age = 1; tx_who = w;
        tx_we   = w ? m1_we : m0_we;
        tx_addr = w ? m1_addr : m0_addr;
        mwd_m   = w ? m1_wdata : m0_wdata;
        maddr_m = tx_addr;
        tx_len  = tx_we ? 2 : lat + 1;
        own_m   = w;
        if (!lk_on) rr_m = !w;
      end
    end
  endtask

  // Requesters: hold the queue head until it is acked, then move on
  task automatic applyStimulus();
    if (ack_e[0] && q0.size() > 0) void'(q0.pop_front());
    if (ack_e[1] && q1.size() > 0) void'(q1.pop_front());
    if (rand_mode) begin
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_txn());
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_txn());
    end
    if (q0.size() > 0) begin
      m0_req = 1; m0_we = q0[0].we; m0_lock = q0[0].lock; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
    end else begin
      m0_req = 0; m0_lock = 0;
    end
    if (q1.size() > 0) begin
      m1_req = 1; m1_we = q1[0].we; m1_lock = q1[0].lock; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
    end else begin
      m1_req = 0; m1_lock = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    model_advance();
    #1;
    applyStimulus();
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    model_reset();
    reset = 1;
    #1;
    @(posedge clk);
    #1;
    checkOutput();
    reset = 0;
    cyc = 0;
  endtask

  task automatic select(input int idx, input int l, input int lm);
    cur = idx; lat = l; lmax = lm;
  endtask

  task automatic chk_order(input string tag, input int idx, input int exp);
    int obs;
    obs = (idx < ack_order.size()) ? ack_order[idx] : -1;
    chk(tag, 32'(obs), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
    mem_arr[8'h20] = 8'h3C;
    rand_mode = 0;
    select(0, 1, 8);

    // Single write, LAT=1
    do_reset();
    q0.push_back(mk(1'b1, 1'b0, 8'h10, 8'hA5));
    applyStimulus();
    run(5);
    chk("wr_ack_cycle", 32'(first_ack[0]), 32'd2);
    chk("wr_strobe_cycles", 32'(mw_cnt), 32'd1);
    chk("wr_strobe_addr", mw_addr_seen, 8'h10);
    chk("wr_strobe_data", mw_data_seen, 8'hA5);
    chk("wr_m1_acks", 32'(ack_cnt[1]), 32'd0);

    // Read, LAT=3
    select(1, 3, 2);
    do_reset();
    q1.push_back(mk(1'b0, 1'b0, 8'h20, 8'h00));
    applyStimulus();
    run(7);
    chk("rd_ack_cycle", 32'(first_ack[1]), 32'd4);
    chk("rd_data", r1_v[cur*8 +: 8], 8'h3C);
    chk("rd_addr_hold", 32'(held_cnt), 32'd3);
    chk("rd_m0_acks", 32'(ack_cnt[0]), 32'd0);

    // Continuous contention, LAT=1
    select(0, 1, 8);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 1'b0, 8'(i), 8'h00));
      q1.push_back(mk(1'b0, 1'b0, 8'(8'h80 + i), 8'h00));
    end
    applyStimulus();
    run(26);
    for (int i = 0; i < 8; i++) chk_order("rr_order", i, i % 2);
    chk("rr_m0_acks", 32'(ack_cnt[0]), 32'd4);
    chk("rr_m1_acks", 32'(ack_cnt[1]), 32'd4);

    // Locked read-modify-write holds off the other requester
    do_reset();
    q0.push_back(mk(1'b0, 1'b1, 8'h05, 8'h00));
    q0.push_back(mk(1'b1, 1'b0, 8'h06, 8'h77));
    q1.push_back(mk(1'b0, 1'b0, 8'h07, 8'h00));
    applyStimulus();
    run(12);
    chk_order("lock_order0", 0, 0);
    chk_order("lock_order1", 1, 0);
    chk_order("lock_order2", 2, 1);
    chk("lock_no_err", lerr_v[cur], 1'b0);

    // Watchdog with LOCK_MAX=2
    select(1, 3, 2);
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 1'b1, 8'(8'h40 + i), 8'h00));
    q1.push_back(mk(1'b0, 1'b0, 8'h50, 8'h00));
    applyStimulus();
    run(17);
    chk_order("wd_order0", 0, 0);
    chk_order("wd_order1", 1, 0);
    chk_order("wd_order2", 2, 1);
    chk("wd_lock_err", lerr_v[cur], 1'b1);

    // Reset in the second ACCESS cycle of a LAT=4 read
    select(2, 4, 8);
    do_reset();
    q0.push_back(mk(1'b0, 1'b0, 8'h33, 8'h00));
    applyStimulus();
    run(2);
    chk("mid_busy_before", busy_v[cur], 1'b1);
    reset = 1;
    #1;
    chk("mid_busy", busy_v[cur], 1'b0);
    chk("mid_mem_write", mw_v[cur], 1'b0);
    chk("mid_m0_ack", ack0_v[cur], 1'b0);
    chk("mid_mem_addr", ma_v[cur*8 +: 8], 8'h00);
    do_reset();
    q0.push_back(mk(1'b1, 1'b0, 8'h44, 8'h99));
    applyStimulus();
    run(6);
    chk("mid_fresh_ack_cycle", 32'(first_ack[0]), 32'd2);
    chk("mid_fresh_acks", 32'(ack_cnt[0]), 32'd1);

    // Randomized traffic on every instance
    rand_mode = 1;
    for (int k = 0; k < 3; k++) begin
      select(k, (k == 0) ? 1 : (k == 1) ? 3 : 4, (k == 1) ? 2 : 8);
      do_reset();
      applyStimulus();
      run(300);
      $display("[TB] random run on dut %0d: %0d acks", k, ack_order.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
